// File: rtl/tmds_encode_8b10b.sv
// TMDS 8b/10b encoder for one HDMI/DVI colour channel.
// Three-stage pipeline: input capture with ones count, transition-minimised
// q_m word, then DC-balancing output selection with running disparity cnt.
// Blanking cycles emit one of four control tokens chosen by {c1,c0}.
module tmds_encode_8b10b (
   input  logic       vga_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] data_in,
   input  logic       c0,
   input  logic       c1,
   input  logic       de,
   output logic [9:0] data_out
);

   // Number of set bits in a byte (0..8).
   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // Transition-minimised word: XNOR chain for ones-heavy bytes, XOR otherwise.
   // Bit 8 records which chain was used (1 = XOR).
   function automatic logic [8:0] build_qm(input logic [7:0] d, input logic [3:0] n1);
      logic       use_xnor;
      logic [8:0] q;
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

   logic        [7:0] data_p0;
   logic              de_p0, c0_p0, c1_p0;
   logic        [3:0] n1_p0;

   logic        [8:0] qm_p1;
   logic        [3:0] n1_qm_p1, n0_qm_p1;
   logic              de_p1, c0_p1, c1_p1;

   logic signed [4:0] cnt;

   logic        [8:0] qm_nxt;
   logic        [3:0] n1_qm_nxt;
   logic signed [4:0] diff;
   logic        [9:0] sym_nxt;
   logic signed [4:0] cnt_nxt;

   // ---- stage 0: capture inputs and count ones ----
   // Register the pixel, controls and the ones count of the pixel.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         data_p0 <= 8'h00;
         de_p0   <= 1'b0;
         c0_p0   <= 1'b0;
         c1_p0   <= 1'b0;
         n1_p0   <= 4'd0;
      end else begin
         data_p0 <= data_in;
         de_p0   <= de;
         c0_p0   <= c0;
         c1_p0   <= c1;
         n1_p0   <= ones8(data_in);
      end
   end

   // ---- stage 1: q_m word and its balance ----
   // Form q_m from the captured pixel and count its ones.
   always_comb begin
      qm_nxt    = build_qm(data_p0, n1_p0);
      n1_qm_nxt = ones8(qm_nxt[7:0]);
   end

   // Register q_m, its ones/zeros counts and the delayed controls.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         qm_p1    <= 9'h000;
         n1_qm_p1 <= 4'd0;
         n0_qm_p1 <= 4'd0;
         de_p1    <= 1'b0;
         c0_p1    <= 1'b0;
         c1_p1    <= 1'b0;
      end else begin
         qm_p1    <= qm_nxt;
         n1_qm_p1 <= n1_qm_nxt;
         n0_qm_p1 <= 4'd8 - n1_qm_nxt;
         de_p1    <= de_p0;
         c0_p1    <= c0_p0;
         c1_p1    <= c1_p0;
      end
   end

   // ---- stage 2: DC balancing and output symbol ----
   // Choose whether to invert q_m so the running disparity is pulled toward 0.
   always_comb begin
      diff    = $signed({1'b0, n1_qm_p1}) - $signed({1'b0, n0_qm_p1});
      sym_nxt = 10'h000;
      cnt_nxt = cnt;
      if (!de_p1) begin
         cnt_nxt = 5'sd0;
         case ({c1_p1, c0_p1})
            2'b00: sym_nxt = 10'h354;
            2'b01: sym_nxt = 10'h0AB;
            2'b10: sym_nxt = 10'h154;
            2'b11: sym_nxt = 10'h2AB;
         endcase
      end else if ((cnt == 5'sd0) || (n1_qm_p1 == n0_qm_p1)) begin
         sym_nxt = {~qm_p1[8], qm_p1[8], qm_p1[8] ? qm_p1[7:0] : ~qm_p1[7:0]};
         cnt_nxt = qm_p1[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (n1_qm_p1 > n0_qm_p1)) ||
                   ((cnt < 5'sd0) && (n0_qm_p1 > n1_qm_p1))) begin
         sym_nxt = {1'b1, qm_p1[8], ~qm_p1[7:0]};
         cnt_nxt = cnt + (qm_p1[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
         sym_nxt = {1'b0, qm_p1[8], qm_p1[7:0]};
         cnt_nxt = cnt + diff - (qm_p1[8] ? 5'sd0 : 5'sd2);
      end
   end

   // Register the output symbol and the running disparity.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         data_out <= 10'h000;
         cnt      <= 5'sd0;
      end else begin
         data_out <= sym_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule
